// File: rtl/serial_addsub_arb.sv
// Bit-serial add/subtract engine: one shared full-adder cell and carry flop,
// time-multiplexed between two requesters by a round-robin arbiter.
// Each accepted operation runs LSB-first over WIDTH cycles.
module serial_addsub_arb #(
  parameter int  WIDTH = 16,
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_vld,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             req0_ack,
  input  logic             req1_vld,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             req1_ack,
  output logic             res_vld,
  output logic             res_id,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_co,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic             prio_q;
  logic             id_q, id_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             res_vld_q, res_id_q, res_co_q, busy_q;
  logic [WIDTH-1:0] res_sum_q;

  logic             grant0, grant1;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic             sel_sub;
  logic             fa_s, fa_co;
  logic             last_bit;

  // Grant only in IDLE and never under reset; on contention the pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst && state_q == IDLE) begin
      if (req0_vld && req1_vld) begin
        if (prio_q) grant1 = 1'b1;
        else        grant0 = 1'b1;
      end else if (req0_vld) begin
        grant0 = 1'b1;
      end else if (req1_vld) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ack = grant0;
  assign req1_ack = grant1;

  // Operand mux feeding the shift registers on a grant.
  always_comb begin
    sel_a   = grant1 ? req1_a   : req0_a;
    sel_b   = grant1 ? req1_b   : req0_b;
    sel_sub = grant1 ? req1_sub : req0_sub;
  end

  // The single shared full-adder cell.
  always_comb begin
    fa_s  = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    fa_co = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  end

  assign last_bit = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  // Datapath next state: load on grant (subtract becomes ~B with carry-in 1), shift in RUN.
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    id_d     = id_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          a_sh_d  = sel_a;
          b_sh_d  = sel_sub ? ~sel_b : sel_b;
          carry_d = sel_sub;
          cnt_d   = '0;
          id_d    = grant1;
        end
      end
      RUN: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        carry_d  = fa_co;
        cnt_d    = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // FSM with registered result outputs; the result is latched on the final RUN edge
  // so it is already visible during the one-cycle DONE strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      id_q      <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      sum_sh_q  <= '0;
      res_vld_q <= 1'b0;
      res_id_q  <= 1'b0;
      res_co_q  <= 1'b0;
      res_sum_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            prio_q  <= grant0;
          end
        end
        RUN: begin
          if (last_bit) begin
            state_q   <= DONE;
            res_vld_q <= 1'b1;
            res_sum_q <= sum_sh_d;
            res_co_q  <= fa_co;
            res_id_q  <= id_q;
          end
        end
        DONE: begin
          state_q   <= IDLE;
          res_vld_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign res_vld = res_vld_q;
  assign res_id  = res_id_q;
  assign res_sum = res_sum_q;
  assign res_co  = res_co_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_serial_addsub_arb.sv
// Bench for serial_addsub_arb: cycle-level behavioural model plus directed
// scenarios with hand-computed results.
module tb_serial_addsub_arb;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         req0_vld, req0_sub, req0_ack;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_vld, req1_sub, req1_ack;
  logic [W-1:0] req1_a, req1_b;
  logic         res_vld, res_id, res_co, busy;
  logic [W-1:0] res_sum;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  int ackIdQ[$];
  int ackCycQ[$];
  int resIdQ[$];
  int resCycQ[$];

  serial_addsub_arb #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0_vld (req0_vld),
    .req0_a   (req0_a),
    .req0_b   (req0_b),
    .req0_sub (req0_sub),
    .req0_ack (req0_ack),
    .req1_vld (req1_vld),
    .req1_a   (req1_a),
    .req1_b   (req1_b),
    .req1_sub (req1_sub),
    .req1_ack (req1_ack),
    .res_vld  (res_vld),
    .res_id   (res_id),
    .res_sum  (res_sum),
    .res_co   (res_co),
    .busy     (busy)
  );

  // Free-running clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference arithmetic: {carry_out, sum} of A+B or A+~B+1, modulo 2^W.
  function automatic logic [W:0] addsub(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] bb;
    bb = {1'b0, (sub ? ~b : b)};
    return {1'b0, a} + bb + {{W{1'b0}}, sub};
  endfunction

  // Behavioural model: phase 0 is idle, 1..W is the serial run, W+1 is the result strobe.
  int         phase = 0;
  bit         mPrio = 1'b0;
  bit         modelOn = 1'b0;
  bit         eAck0, eAck1;
  logic [W:0] pend;
  bit         pendId;
  logic [W-1:0] heldSum = '0;
  bit         heldCo = 1'b0;
  bit         heldId = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      eAck0 = 1'b0;
      eAck1 = 1'b0;
      if (!rst && phase == 0) begin
        if (req0_vld && req1_vld) begin
          if (mPrio) eAck1 = 1'b1;
          else       eAck0 = 1'b1;
        end else if (req0_vld) begin
          eAck0 = 1'b1;
        end else if (req1_vld) begin
          eAck1 = 1'b1;
        end
      end
      if (modelOn) begin
        checkOutput("mon_ack0", req0_ack, eAck0);
        checkOutput("mon_ack1", req1_ack, eAck1);
        checkOutput("mon_busy", busy, phase != 0);
        checkOutput("mon_res_vld", res_vld, phase == W + 1);
        checkOutput("mon_res_sum", res_sum, heldSum);
        checkOutput("mon_res_co", res_co, heldCo);
        checkOutput("mon_res_id", res_id, heldId);
        if (req0_ack === 1'b1) begin ackIdQ.push_back(0); ackCycQ.push_back(cycle); end
        if (req1_ack === 1'b1) begin ackIdQ.push_back(1); ackCycQ.push_back(cycle); end
        if (res_vld === 1'b1) begin resIdQ.push_back(int'(res_id)); resCycQ.push_back(cycle); end
      end
      if (rst) begin
        phase   = 0;
        mPrio   = 1'b0;
        heldSum = '0;
        heldCo  = 1'b0;
        heldId  = 1'b0;
        modelOn = 1'b1;
      end else if (phase == 0) begin
        if (eAck0 || eAck1) begin
          pend   = eAck1 ? addsub(req1_a, req1_b, req1_sub) : addsub(req0_a, req0_b, req0_sub);
          pendId = eAck1;
          mPrio  = eAck0;
          phase  = 1;
        end
      end else if (phase < W + 1) begin
        phase++;
        if (phase == W + 1) begin
          heldSum = pend[W-1:0];
          heldCo  = pend[W];
          heldId  = pendId;
        end
      end else begin
        phase = 0;
      end
    end
  end

  // Present one request, wait (bounded) for its ack, then withdraw it.
  task automatic applyStimulus(input bit which, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit sub, output int ackCyc);
    bit got;
    got    = 1'b0;
    ackCyc = -1;
    @(posedge clk); #1;
    if (which) begin
      req1_vld = 1'b1; req1_a = a; req1_b = b; req1_sub = sub;
    end else begin
      req0_vld = 1'b1; req0_a = a; req0_b = b; req0_sub = sub;
    end
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if ((which ? req1_ack : req0_ack) === 1'b1) begin
        got    = 1'b1;
        ackCyc = cycle;
      end
    end
    checkOutput("ack_seen", got, 1'b1);
    @(posedge clk); #1;
    if (which) req1_vld = 1'b0;
    else       req0_vld = 1'b0;
  endtask

  task automatic waitResult(output int resCyc);
    bit got;
    got    = 1'b0;
    resCyc = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (res_vld === 1'b1) begin
        got    = 1'b1;
        resCyc = cycle;
      end
    end
    checkOutput("res_seen", got, 1'b1);
  endtask

  task automatic waitIdle();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (busy === 1'b0) got = 1'b1;
    end
    checkOutput("idle_seen", got, 1'b1);
  endtask

  task automatic pulseReset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic runOp(input string name, input bit which, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit sub, input logic [W-1:0] expSum, input bit expCo);
    int ackCyc, resCyc;
    applyStimulus(which, a, b, sub, ackCyc);
    waitResult(resCyc);
    checkOutput({name, "_latency"}, resCyc - ackCyc, W + 1);
    checkOutput({name, "_sum"}, res_sum, expSum);
    checkOutput({name, "_co"}, res_co, expCo);
    checkOutput({name, "_id"}, res_id, which);
  endtask

  // Directed scenarios.
  initial begin
    int k, hit, nextAck;
    bit got;
    rst = 1'b1;
    req0_vld = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_vld = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_res_vld", res_vld, 1'b0);
    checkOutput("reset_res_sum", res_sum, 16'h0000);
    checkOutput("reset_res_co", res_co, 1'b0);
    checkOutput("reset_res_id", res_id, 1'b0);

    runOp("add",     1'b0, 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0);
    runOp("wrap",    1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    runOp("sub_neg", 1'b0, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
    runOp("sub_pos", 1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1);

    // Contention: both held continuously after a reset.
    waitIdle();
    pulseReset();
    ackIdQ.delete(); ackCycQ.delete(); resIdQ.delete(); resCycQ.delete();
    req0_a = 16'h0010; req0_b = 16'h0001; req0_sub = 1'b0; req0_vld = 1'b1;
    req1_a = 16'h0020; req1_b = 16'h0001; req1_sub = 1'b1; req1_vld = 1'b1;
    repeat (75) @(posedge clk);
    #1 req0_vld = 1'b0; req1_vld = 1'b0;
    checkOutput("cont_nacks", ackIdQ.size() >= 4, 1'b1);
    checkOutput("cont_nres", resIdQ.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (ackIdQ.size() > i) checkOutput("cont_ack_order", ackIdQ[i], i % 2);
      if (ackIdQ.size() > i && i > 0) checkOutput("cont_ack_spacing", ackCycQ[i] - ackCycQ[i-1], W + 2);
      if (resIdQ.size() > i) checkOutput("cont_res_order", resIdQ[i], i % 2);
    end
    waitIdle();

    // Reset mid-operation: pointer is 1 going in, must come back as 0.
    @(posedge clk); #1;
    req0_a = 16'h00F0; req0_b = 16'h000F; req0_sub = 1'b0; req0_vld = 1'b1;
    got = 1'b0;
    k = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req0_ack === 1'b1) begin got = 1'b1; k = cycle; end
    end
    checkOutput("mid_ack_seen", got, 1'b1);
    @(posedge clk); #1;
    req1_a = 16'h0002; req1_b = 16'h0003; req1_sub = 1'b1; req1_vld = 1'b1;
    for (int i = 0; i < 10 && cycle < k + 5; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_busy", busy, 1'b0);
    checkOutput("mid_res_vld", res_vld, 1'b0);
    checkOutput("mid_next_ack0", req0_ack, 1'b1);
    checkOutput("mid_next_ack1", req1_ack, 1'b0);
    @(posedge clk); #1;
    req0_vld = 1'b0; req1_vld = 1'b0;
    waitResult(hit);
    checkOutput("mid_res_sum", res_sum, 16'h00FF);
    checkOutput("mid_res_id", res_id, 1'b0);
    hit = 0;
    foreach (resCycQ[i]) if (resCycQ[i] == k + W + 1) hit = 1;
    checkOutput("mid_dropped", hit, 0);

    // Hold behaviour: req1 raised during RUN waits for the next IDLE cycle.
    @(posedge clk); #1;
    req0_a = 16'h0100; req0_b = 16'h0023; req0_sub = 1'b0; req0_vld = 1'b1;
    @(negedge clk);
    checkOutput("hold_ack0", req0_ack, 1'b1);
    k = cycle;
    @(posedge clk); #1;
    req0_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req1_a = 16'h0002; req1_b = 16'h0003; req1_sub = 1'b1; req1_vld = 1'b1;
    got = 1'b0;
    nextAck = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (cycle < k + W + 1) checkOutput("hold_sum_prev", res_sum, 16'h00FF);
      if (cycle == k + W + 1) begin
        checkOutput("hold_res_vld", res_vld, 1'b1);
        checkOutput("hold_sum_new", res_sum, 16'h0123);
      end
      if (req1_ack === 1'b1) begin got = 1'b1; nextAck = cycle; end
    end
    checkOutput("hold_ack1_seen", got, 1'b1);
    checkOutput("hold_ack1_cycle", nextAck - k, W + 2);
    @(posedge clk); #1;
    req1_vld = 1'b0;
    waitResult(hit);
    checkOutput("hold_r1_sum", res_sum, 16'hFFFF);
    checkOutput("hold_r1_co", res_co, 1'b0);
    checkOutput("hold_r1_id", res_id, 1'b1);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub_arb.md
# serial_addsub_arb

Bit-serial add/subtract engine for the ECC core. It shares one full-adder cell and a carry flop between two requesters using round-robin arbitration. Each accepted operation runs LSB-first over WIDTH cycles and returns a WIDTH-bit sum plus carry-out. It sits between the field-arithmetic sequencers and the single full-adder instance, and gives area-constrained reduction and compare steps a shared adder.

## Interface
- WIDTH, 16, operand/result width in bits; legal range 2..256.
- CNT_W, $clog2(WIDTH), width of the bit counter; derived, not overridden.

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_vld  in  1  requester 0 has an operation pending.
- req0_a  in  WIDTH  operand A of requester 0.
- req0_b  in  WIDTH  operand B of requester 0.
- req0_sub  in  1  1 = A−B, 0 = A+B.
- req0_ack  out  1  combinational grant; operands are captured at the end of this cycle.
- req1_vld / req1_a / req1_b / req1_sub / req1_ack  same as requester 0.
- res_vld  out  1  one-cycle result strobe.
- res_id  out  1  requester index that owns the result.
- res_sum  out  WIDTH  result; holds its value between strobes.
- res_co  out  1  carry-out; for subtraction, 1 = no borrow (A ≥ B).
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - If any req*_vld is high, grant exactly one requester: assert its ack, load the shift registers, clear cnt, and go to RUN.
  - Otherwise stay in IDLE.
- Loading on grant:
  - a_sh ← A.
  - b_sh ← sub ? ~B : B.
  - carry ← sub.
  - id ← granted index.
- Arbitration:
  - Pointer prio resets to 0.
  - If both requesters are valid, grant prio.
  - After any grant, prio ← the index that was not granted.
- RUN, every cycle:
  - Compute {co, s} = full_adder(a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by one.
  - Shift s into sum_sh from the MSB side.
  - carry ← co; cnt ← cnt+1.
  - When cnt == WIDTH−1, go to DONE.
- DONE, one cycle:
  - res_vld = 1; res_sum ← sum_sh; res_co ← carry; res_id ← id.
  - Return to IDLE.
- Arithmetic is modulo 2^WIDTH; there is no saturation. Subtraction is two's complement (~B + 1).
- A request arriving in RUN or DONE is not acked. The requester must hold vld, A, B and sub stable until its ack.
- Ack is never asserted outside IDLE and never to both requesters in the same cycle.
- Reset in any state, including mid-RUN:
  - The next state is IDLE and the in-flight operation is dropped with no res_vld.
  - prio = 0.
  - res_vld = 0, res_id = 0, res_sum = 0, res_co = 0, busy = 0.
  - Both acks are 0 while rst is high.

## Timing
- Ack in cycle k means RUN occupies k+1 .. k+WIDTH, and res_vld is high in cycle k+WIDTH+1.
- The earliest next ack is cycle k+WIDTH+2. Throughput is one operation per WIDTH+2 cycles.
- res_sum, res_co and res_id update only at the DONE edge. They are stable from the cycle res_vld is high until the next DONE.
- Acks are combinational from req*_vld, state and prio. All other outputs are registered.
- busy rises the cycle after ack and falls the cycle after res_vld.

## Test plan
- Single add, req0 only, WIDTH=16: a=0x1234, b=0x0FED, sub=0 → req0_ack in cycle k; res_vld in k+17 with res_sum=0x2221, res_co=0, res_id=0.
- Wrap-around: a=0xFFFF, b=0x0001, sub=0 → res_sum=0x0000, res_co=1.
- Subtract, two cases:
  - a=0x0005, b=0x0007, sub=1 → res_sum=0xFFFE, res_co=0.
  - a=0x0007, b=0x0005, sub=1 → res_sum=0x0002, res_co=1.
- Contention: after reset, hold req0_vld and req1_vld high continuously → ack order is 0,1,0,1, each ack 18 cycles apart; res_id alternates 0,1,0,1; never both acks in one cycle.
- Reset mid-operation: assert rst for one cycle at k+5 → busy=0 and res_vld never pulses for that operation; with req1 and req0 both held, the next ack goes to req0 (prio reset to 0).
- Hold behaviour: raise req1_vld during RUN → no req1_ack until the IDLE cycle following res_vld; res_sum keeps its previous value throughout.
